// File: rtl/gf2m_pkg.sv
// Shared GF(2^83) definitions: sequencer states, default field width and the
// trinomial-free pentanomial taps f(x) = x^83 + x^7 + x^4 + x^2 + 1.
package gf2m_pkg;

    localparam int GF2M_WIDTH = 83;
    localparam int GF2M_K3    = 7;
    localparam int GF2M_K2    = 4;
    localparam int GF2M_K1    = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MSTART,
        MWAIT,
        DONE
    } state_t;

endpackage

// File: rtl/gf2m_inner_prod.sv
// Inner-product sequencer c = sum(a_i*b_i) driving an external field multiplier; optional GF2M_INNER_PROD_ZERO_SKIP_EN.
// Latency: L+2 cycles per pair (1 cycle per skipped zero pair); len=0 yields out_valid 1 cycle after start.
// Backpressure: in_ready only in LOAD; result held in DONE until out_ready; start ignored unless IDLE.
module gf2m_inner_prod
    import gf2m_pkg::*;
#(
    parameter int WIDTH = GF2M_WIDTH,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_op_a,
    output logic [WIDTH-1:0] mul_op_b,
    input  logic             mul_done,
    input  logic [WIDTH-1:0] mul_op_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc;
    logic [LEN_W-1:0] cnt;
    logic             zero_pair;

`ifdef GF2M_INNER_PROD_ZERO_SKIP_EN
    assign zero_pair = (in_a == '0) || (in_b == '0);
`else
    assign zero_pair = 1'b0;
`endif

    // Outputs decode straight from state so an async reset clears them at once.
    assign in_ready  = (state == LOAD);
    assign mul_start = (state == MSTART);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = acc;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    if (zero_pair) begin
                        state_nxt = (cnt == LEN_W'(1)) ? DONE : LOAD;
                    end else begin
                        state_nxt = MSTART;
                    end
                end
            end
            MSTART: state_nxt = MWAIT;
            MWAIT: begin
                if (mul_done) begin
                    state_nxt = (cnt == '0) ? DONE : LOAD;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            acc      <= '0;
            cnt      <= '0;
            mul_op_a <= '0;
            mul_op_b <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        cnt <= len;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        cnt <= cnt - LEN_W'(1);
                        if (!zero_pair) begin
                            mul_op_a <= in_a;
                            mul_op_b <= in_b;
                        end
                    end
                end
                MWAIT: begin
                    // Products arrive already reduced; field addition is XOR.
                    if (mul_done) begin
                        acc <= acc ^ mul_op_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gf2m_inner_prod.sv
// Directed bench for gf2m_inner_prod with a 7-cycle behavioural GF(2^83) multiplier.
module tb_gf2m_inner_prod;
    import gf2m_pkg::*;

    localparam int W = 83;

    logic         clk = 1'b0;
    logic         rst_b = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   len = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         mul_start;
    logic [W-1:0] mul_op_a, mul_op_b, mul_op_c;
    logic         mul_done;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         busy;

    int passes = 0;
    int total  = 0;
    int mstart_cnt = 0;
    int overlap_cnt = 0;

    logic [W-1:0] pa [8];
    logic [W-1:0] pb [8];

    gf2m_inner_prod #(.WIDTH(W), .LEN_W(8)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_start(mul_start), .mul_op_a(mul_op_a), .mul_op_b(mul_op_b),
        .mul_done(mul_done), .mul_op_c(mul_op_c),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] gfmul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-2:0] p;
        p = '0;
        for (int i = 0; i < W; i++)
            if (b[i]) p = p ^ ({{(W-1){1'b0}}, a} << i);
        for (int i = 2*W-2; i >= W; i--) begin
            if (p[i]) begin
                p[i]                 = 1'b0;
                p[i-W]               = p[i-W] ^ 1'b1;
                p[i-W+GF2M_K1]       = p[i-W+GF2M_K1] ^ 1'b1;
                p[i-W+GF2M_K2]       = p[i-W+GF2M_K2] ^ 1'b1;
                p[i-W+GF2M_K3]       = p[i-W+GF2M_K3] ^ 1'b1;
            end
        end
        return p[W-1:0];
    endfunction

    // Multiplier stand-in: done 7 cycles after the start cycle, reset with the block.
    logic [6:0] msr;
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) msr <= '0;
        else        msr <= {msr[5:0], mul_start};
    end
    assign mul_done = msr[6];
    assign mul_op_c = gfmul(mul_op_a, mul_op_b);

    always @(posedge clk) if (mul_start) mstart_cnt++;
    always @(negedge clk) if (in_ready && out_valid) overlap_cnt++;

    // Runs one inner product up to the DONE state; handshake left to the caller.
    task automatic do_run(input int n, output int timed_out, output int starts);
        int s0;
        int k;
        s0 = mstart_cnt;
        timed_out = 0;
        @(negedge clk); start = 1'b1; len = 8'(n);
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < n; i++) begin
            k = 0;
            while (!in_ready && k < 50) begin @(negedge clk); k++; end
            if (k >= 50) begin timed_out = 1; starts = mstart_cnt - s0; return; end
            in_valid = 1'b1; in_a = pa[i]; in_b = pb[i];
            @(negedge clk); in_valid = 1'b0;
        end
        k = 0;
        while (!out_valid && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) timed_out = 1;
        starts = mstart_cnt - s0;
    endtask

    task automatic finish_run();
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (busy !== 1'b0)      $display("FAIL reset_busy got %0b want 0", busy);      else passes++;
        total++; if (in_ready !== 1'b0)  $display("FAIL reset_in_ready got %0b want 0", in_ready); else passes++;
        total++; if (mul_start !== 1'b0) $display("FAIL reset_mul_start got %0b want 0", mul_start); else passes++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else passes++;
        total++; if (result !== '0 || mul_op_a !== '0 || mul_op_b !== '0)
            $display("FAIL reset_data result=%h op_a=%h op_b=%h want 0", result, mul_op_a, mul_op_b); else passes++;
        rst_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int s0;
        int n;
        s0 = mstart_cnt;
        start = 1'b1; len = 8'd1; in_valid = 1'b1; in_a = 83'h1; in_b = 83'h2;
        @(negedge clk); start = 1'b0;
        total++; if (in_ready !== 1'b1) $display("FAIL single_first_ready got %0b want 1", in_ready); else passes++;
        n = 1;
        @(negedge clk); in_valid = 1'b0; n = 2;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        total++; if (n !== 10) $display("FAIL single_latency got %0d want 10", n); else passes++;
        total++; if (result !== 83'h2) $display("FAIL single_result got %h want 2", result); else passes++;
        total++; if (mstart_cnt - s0 !== 1) $display("FAIL single_mul_starts got %0d want 1", mstart_cnt - s0); else passes++;
        finish_run();
    endtask

    task automatic test_reduction();
        int to, st;
        pa[0] = '0; pa[0][82] = 1'b1; pb[0] = 83'h2;
        pa[1] = 83'h1; pb[1] = 83'h1;
        do_run(2, to, st);
        total++; if (to !== 0) $display("FAIL reduction_timeout got %0d want 0", to); else passes++;
        total++; if (result !== 83'h94) $display("FAIL reduction_result got %h want 94", result); else passes++;
        total++; if (st !== 2) $display("FAIL reduction_mul_starts got %0d want 2", st); else passes++;
        finish_run();
    endtask

    task automatic test_empty();
        int s0;
        s0 = mstart_cnt;
        start = 1'b1; len = 8'd0;
        @(negedge clk); start = 1'b0;
        total++; if (out_valid !== 1'b1) $display("FAIL empty_out_valid got %0b want 1", out_valid); else passes++;
        total++; if (result !== '0) $display("FAIL empty_result got %h want 0", result); else passes++;
        finish_run();
        total++; if (mstart_cnt - s0 !== 0) $display("FAIL empty_mul_starts got %0d want 0", mstart_cnt - s0); else passes++;
    endtask

    task automatic test_backpressure();
        int s0, bad, k;
        s0 = mstart_cnt; bad = 0;
        start = 1'b1; len = 8'd1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!in_ready || !busy) bad++;
            @(negedge clk);
        end
        total++; if (bad !== 0 || mstart_cnt != s0)
            $display("FAIL bp_in_hold bad=%0d starts=%0d want 0/0", bad, mstart_cnt - s0); else passes++;
        in_valid = 1'b1; in_a = 83'h3; in_b = 83'h3;
        @(negedge clk); in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 40) begin @(negedge clk); k++; end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!out_valid || in_ready || result !== 83'h5) bad++;
            @(negedge clk);
        end
        total++; if (bad !== 0) $display("FAIL bp_out_hold bad_cycles=%0d want 0 (result=%h)", bad, result); else passes++;
        total++; if (result !== 83'h5) $display("FAIL bp_result got %h want 5", result); else passes++;
        finish_run();
    endtask

    task automatic test_reset_mid();
        int k, to, st;
        start = 1'b1; len = 8'd1; in_valid = 1'b1; in_a = 83'h7; in_b = 83'h9;
        @(negedge clk); start = 1'b0;
        @(negedge clk); in_valid = 1'b0;
        k = 0;
        while (!mul_start && k < 10) begin @(negedge clk); k++; end
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0 || mul_start !== 1'b0 || result !== '0)
            $display("FAIL midreset_outputs out_valid=%0b busy=%0b mul_start=%0b result=%h want 0", out_valid, busy, mul_start, result);
        else passes++;
        @(negedge clk); rst_b = 1'b1;
        @(negedge clk);
        pa[0] = '0; pa[0][82] = 1'b1; pb[0] = 83'h2;
        do_run(1, to, st);
        total++; if (to !== 0 || result !== 83'h95 || st !== 1)
            $display("FAIL midreset_rerun to=%0d result=%h starts=%0d want 0/95/1", to, result, st); else passes++;
        finish_run();
    endtask

    task automatic test_ignored_start();
        int k;
        start = 1'b1; len = 8'd1;
        @(negedge clk); start = 1'b0;
        start = 1'b1; len = 8'd5;
        @(negedge clk); start = 1'b0;
        in_valid = 1'b1; in_a = 83'h2; in_b = 83'h2;
        @(negedge clk); in_valid = 1'b0;
        k = 0;
        while (!out_valid && !in_ready && k < 40) begin @(negedge clk); k++; end
        total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 83'h4)
            $display("FAIL busy_start_ignored out_valid=%0b in_ready=%0b result=%h want 1/0/4", out_valid, in_ready, result);
        else passes++;
        out_ready = 1'b1; start = 1'b1; len = 8'd1;
        @(negedge clk); out_ready = 1'b0; start = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL done_start_ignored busy got %0b want 0", busy); else passes++;
        @(negedge clk);
    endtask

    task automatic test_zero_skip();
        int to, st, want_st;
        pa[0] = 83'h0; pb[0] = 83'h2;
        pa[1] = 83'h2; pb[1] = 83'h1;
        pa[2] = 83'h1; pb[2] = 83'h0;
`ifdef GF2M_INNER_PROD_ZERO_SKIP_EN
        want_st = 1;
`else
        want_st = 3;
`endif
        do_run(3, to, st);
        total++; if (to !== 0) $display("FAIL zskip_timeout got %0d want 0", to); else passes++;
        total++; if (result !== 83'h2) $display("FAIL zskip_result got %h want 2", result); else passes++;
        total++; if (st !== want_st) $display("FAIL zskip_mul_starts got %0d want %0d", st, want_st); else passes++;
        finish_run();
    endtask

    initial begin
        test_reset();
        test_single();
        test_reduction();
        test_empty();
        test_backpressure();
        test_reset_mid();
        test_ignored_start();
        test_zero_skip();
        total++; if (overlap_cnt !== 0) $display("FAIL ready_valid_overlap got %0d want 0", overlap_cnt); else passes++;
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
